// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared memory-port types, arbiter state encoding and winner selection
//
// Purpose: types shared by the cache FSMs, the memory controller and mem_port_arbiter.
//   mem_req_type   : cache/arbiter -> memory request (addr, line data, rw, valid)
//   mem_data_type  : memory -> cache/arbiter response (line data, ready)
//   arb_state_type : arbiter FSM states
//   pick_winner    : round-robin choice with write-back lock override
package mem_port_arbiter_pkg;

  localparam int ARB_PORTS = 2;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_type;

  // lock_rw: the last completed transaction was a write-back (and locking is enabled).
  // With nothing full the result is don't-care; the caller only uses it when a slot is full.
  function automatic logic pick_winner(input logic [1:0] full,
                                       input logic       last_grant,
                                       input logic       lock_rw);
    logic w;
    if (lock_rw && full[last_grant]) begin
      w = last_grant;
    end else if (&full) begin
      w = ~last_grant;
    end else begin
      w = full[1];
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_slot.sv
// rtl/mem_port_arbiter_slot.sv - single-entry request capture register with sticky overflow flag
//
// Purpose: turns a one-cycle request pulse from a cache FSM into a held request until granted.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   req_i       : request from the cache; valid is a one-cycle pulse
//   take_i      : the arbiter grants this slot at this edge (slot empties)
//   full_o      : slot holds a request
//   payload_o   : held request
//   overflow_o  : sticky, a pulse arrived while the slot was full and not being emptied
module arb_req_slot
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  mem_req_type req_i,
  input  logic        take_i,
  output logic        full_o,
  output mem_req_type payload_o,
  output logic        overflow_o
);

  logic        full_q, full_d;
  mem_req_type payload_q, payload_d;
  logic        ovf_q, ovf_d;

  always_comb begin
    // Emptying is applied first so a pulse on the grant edge lands in the freed slot.
    full_d    = full_q & ~take_i;
    payload_d = payload_q;
    ovf_d     = ovf_q;
    if (req_i.valid) begin
      if (!full_d) begin
        full_d    = 1'b1;
        payload_d = req_i;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= 1'b0;
      payload_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      payload_q <= payload_d;
      ovf_q     <= ovf_d;
    end
  end

  assign full_o     = full_q;
  assign payload_o  = payload_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between I-cache and D-cache
//
// Purpose: captures request pulses from two cache FSMs, serialises them onto one memory port
// and routes each completion back to the cache that owns the transaction.
// Ports:
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   cache0_req       : port 0 (I-cache) request, valid is a one-cycle pulse
//   cache1_req       : port 1 (D-cache) request, valid is a one-cycle pulse
//   cache0_data      : port 0 response (ready only when port 0 owns the transaction)
//   cache1_data      : port 1 response (ready only when port 1 owns the transaction)
//   mem_req          : registered request to memory, held until mem_data.ready
//   mem_data         : memory response, ready is a one-cycle completion
//   owner            : granted port, meaningful while busy
//   busy             : a memory transaction is outstanding
//   err_overflow     : sticky per port, pulse lost because that port's slot was full
//   err_timeout      : sticky, a transaction stayed busy for TIMEOUT_CYCLES cycles
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit WB_LOCK        = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  cache0_req,
  input  mem_req_type  cache1_req,
  output mem_data_type cache0_data,
  output mem_data_type cache1_data,
  output mem_req_type  mem_req,
  input  mem_data_type mem_data,
  output logic         owner,
  output logic         busy,
  output logic [1:0]   err_overflow,
  output logic         err_timeout
);

  localparam logic [31:0] TIMEOUT_U   = TIMEOUT_CYCLES;
  localparam bit          TIMEOUT_ENA = (TIMEOUT_CYCLES != 0);

  logic [1:0]    slot_full;
  logic [1:0]    slot_ovf;
  logic [1:0]    slot_take;
  mem_req_type   slot_req [ARB_PORTS];

  arb_state_type state_q, state_d;
  mem_req_type   mem_req_q, mem_req_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          last_rw_q, last_rw_d;
  logic [15:0]   wd_q, wd_d;
  logic [15:0]   wd_inc;
  logic          timeout_q, timeout_d;
  logic          winner;
  logic          busy_w;

  arb_req_slot u_slot0 (
    .clk        (clk),
    .rst        (rst),
    .req_i      (cache0_req),
    .take_i     (slot_take[0]),
    .full_o     (slot_full[0]),
    .payload_o  (slot_req[0]),
    .overflow_o (slot_ovf[0])
  );

  arb_req_slot u_slot1 (
    .clk        (clk),
    .rst        (rst),
    .req_i      (cache1_req),
    .take_i     (slot_take[1]),
    .full_o     (slot_full[1]),
    .payload_o  (slot_req[1]),
    .overflow_o (slot_ovf[1])
  );

  // last_grant resets to 1 so port 0 wins the very first contention.
  assign winner = pick_winner(slot_full, last_grant_q, last_rw_q & WB_LOCK);
  assign busy_w = (state_q == ARB_BUSY);

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    last_rw_d    = last_rw_q;
    wd_d         = wd_q;
    timeout_d    = timeout_q;
    slot_take    = 2'b00;
    wd_inc       = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
    case (state_q)
      ARB_IDLE: begin
        if (|slot_full) begin
          mem_req_d         = slot_req[winner];
          mem_req_d.valid   = 1'b1;
          owner_d           = winner;
          slot_take[winner] = 1'b1;
          wd_d              = 16'd0;
          state_d           = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        wd_d = wd_inc;
        // The watchdog only flags; the transaction keeps waiting for memory.
        if (TIMEOUT_ENA && ({16'd0, wd_inc} >= TIMEOUT_U)) begin
          timeout_d = 1'b1;
        end
        if (mem_data.ready) begin
          last_grant_d = owner_q;
          last_rw_d    = mem_req_q.rw;
          mem_req_d    = '0;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      mem_req_q    <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      last_rw_q    <= 1'b0;
      wd_q         <= 16'd0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      last_rw_q    <= last_rw_d;
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
    end
  end

  // Completion is routed combinationally; a ready while idle reaches nobody.
  always_comb begin
    cache0_data.data  = mem_data.data;
    cache1_data.data  = mem_data.data;
    cache0_data.ready = mem_data.ready & busy_w & ~owner_q;
    cache1_data.ready = mem_data.ready & busy_w & owner_q;
  end

  assign mem_req      = mem_req_q;
  assign owner        = owner_q;
  assign busy         = busy_w;
  assign err_overflow = slot_ovf;
  assign err_timeout  = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TMO = 8;
  localparam logic [31:0] A0 = 32'h0000_1230;
  localparam logic [31:0] A1 = 32'h0000_4560;
  localparam logic [31:0] A2 = 32'h0000_7890;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  mem_req_type  c0_req, c1_req, mreq;
  mem_data_type c0_data, c1_data, mdata;
  logic         owner, busy, err_to;
  logic [1:0]   err_ovf;

  int passed = 0;
  int total  = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TMO), .WB_LOCK(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .cache0_req   (c0_req),
    .cache1_req   (c1_req),
    .cache0_data  (c0_data),
    .cache1_data  (c1_data),
    .mem_req      (mreq),
    .mem_data     (mdata),
    .owner        (owner),
    .busy         (busy),
    .err_overflow (err_ovf),
    .err_timeout  (err_to)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    bit          rs;
    bit          v0;
    logic [31:0] a0;
    bit          rw0;
    bit          v1;
    logic [31:0] a1;
    bit          rw1;
    bit          rdy;
    bit          ev;
    logic [31:0] ea;
    bit          erw;
    bit          eown;
    bit          eb;
    bit          ec0;
    bit          ec1;
    logic [1:0]  eovf;
  } vec_t;

  vec_t tv[$];

  function automatic logic [127:0] data_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
  endfunction

  function automatic vec_t row(input int n, input bit v0, input logic [31:0] a0, input bit rw0,
                               input bit v1, input logic [31:0] a1, input bit rw1, input bit rdy,
                               input bit ev, input logic [31:0] ea, input bit erw, input bit eown,
                               input bit eb, input bit ec0, input bit ec1, input logic [1:0] eovf);
    vec_t r;
    r.n = n; r.rs = 1'b0; r.v0 = v0; r.a0 = a0; r.rw0 = rw0; r.v1 = v1; r.a1 = a1; r.rw1 = rw1;
    r.rdy = rdy; r.ev = ev; r.ea = ea; r.erw = erw; r.eown = eown; r.eb = eb;
    r.ec0 = ec0; r.ec1 = ec1; r.eovf = eovf;
    return r;
  endfunction

  function automatic vec_t rst_row();
    vec_t r;
    r = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    r.rs = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input bit v0, input logic [31:0] a0, input bit rw0,
                       input bit v1, input logic [31:0] a1, input bit rw1, input bit rdy);
    c0_req.addr = a0; c0_req.data = data_of(a0); c0_req.rw = rw0; c0_req.valid = v0;
    c1_req.addr = a1; c1_req.data = data_of(a1); c1_req.rw = rw1; c1_req.valid = v1;
    mdata.ready = rdy;
    mdata.data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic step(input bit v0, input logic [31:0] a0, input bit rw0,
                      input bit v1, input logic [31:0] a1, input bit rw1, input bit rdy);
    @(negedge clk);
    drive(v0, a0, rw0, v1, a1, rw1, rdy);
    #1;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic exp_out(input string tag, input bit ev, input logic [31:0] ea, input bit erw,
                         input bit eown, input bit eb, input bit ec0, input bit ec1,
                         input logic [1:0] eovf, input bit eto);
    chk({tag, ".valid"}, 128'(mreq.valid), 128'(ev));
    chk({tag, ".busy"}, 128'(busy), 128'(eb));
    chk({tag, ".c0_ready"}, 128'(c0_data.ready), 128'(ec0));
    chk({tag, ".c1_ready"}, 128'(c1_data.ready), 128'(ec1));
    chk({tag, ".err_overflow"}, 128'(err_ovf), 128'(eovf));
    chk({tag, ".err_timeout"}, 128'(err_to), 128'(eto));
    if (ev) begin
      chk({tag, ".addr"}, 128'(mreq.addr), 128'(ea));
      chk({tag, ".rw"}, 128'(mreq.rw), 128'(erw));
      chk({tag, ".data"}, mreq.data, data_of(ea));
      chk({tag, ".owner"}, 128'(owner), 128'(eown));
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("reset.mem_req", 128'(mreq), 128'(0));
    chk("reset.owner", 128'(owner), 128'(0));
    exp_out("reset", 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    mdata.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_pend [2];
  mem_req_type m_slot [2];
  bit          m_busy, m_own, m_lg, m_lrw, m_to;
  mem_req_type m_cur;
  int          m_cnt;
  bit [1:0]    m_ovf;

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0; m_busy = 0; m_own = 0;
    m_lg = 1; m_lrw = 0; m_to = 0; m_cnt = 0; m_ovf = 2'b00;
  endtask

  task automatic model_edge(input mem_req_type r0, input mem_req_type r1, input bit rdy);
    int w;
    mem_req_type rq [2];
    rq[0] = r0; rq[1] = r1;
    if (m_busy) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt >= TMO) m_to = 1;
      if (rdy) begin
        m_busy = 0; m_lg = m_own; m_lrw = m_cur.rw;
      end
    end else if (m_pend[0] || m_pend[1]) begin
      if (m_lrw && m_pend[m_lg]) w = int'(m_lg);
      else if (m_pend[0] && m_pend[1]) w = m_lg ? 0 : 1;
      else w = m_pend[0] ? 0 : 1;
      m_cur = m_slot[w]; m_own = (w == 1); m_busy = 1; m_cnt = 0; m_pend[w] = 0;
    end
    for (int n = 0; n < 2; n++) begin
      if (rq[n].valid) begin
        if (!m_pend[n]) begin m_pend[n] = 1; m_slot[n] = rq[n]; end
        else m_ovf[n] = 1;
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);

    // Test 1: single port-0 pulse; Test 2: simultaneous pulses; Test 4: overflow on port 1.
    tv.push_back(rst_row());
    tv.push_back(row(5, 0,0,0,  0,0,0,  0,  0,0,0,0, 0, 0,0, 2'b00));
    tv.push_back(row(1, 1,A0,0, 0,0,0,  0,  0,0,0,0, 0, 0,0, 2'b00));
    tv.push_back(row(1, 0,0,0,  0,0,0,  0,  0,0,0,0, 0, 0,0, 2'b00));
    tv.push_back(row(5, 0,0,0,  0,0,0,  0,  1,A0,0,0, 1, 0,0, 2'b00));
    tv.push_back(row(1, 0,0,0,  0,0,0,  1,  1,A0,0,0, 1, 1,0, 2'b00));
    tv.push_back(row(2, 0,0,0,  0,0,0,  0,  0,0,0,0, 0, 0,0, 2'b00));
    tv.push_back(rst_row());
    tv.push_back(row(5, 0,0,0,  0,0,0,  0,  0,0,0,0, 0, 0,0, 2'b00));
    tv.push_back(row(1, 1,A0,0, 1,A1,0, 0,  0,0,0,0, 0, 0,0, 2'b00));
    tv.push_back(row(1, 0,0,0,  0,0,0,  0,  0,0,0,0, 0, 0,0, 2'b00));
    tv.push_back(row(2, 0,0,0,  0,0,0,  0,  1,A0,0,0, 1, 0,0, 2'b00));
    tv.push_back(row(1, 0,0,0,  0,0,0,  1,  1,A0,0,0, 1, 1,0, 2'b00));
    tv.push_back(row(1, 0,0,0,  0,0,0,  0,  0,0,0,0, 0, 0,0, 2'b00));
    tv.push_back(row(2, 0,0,0,  0,0,0,  0,  1,A1,0,1, 1, 0,0, 2'b00));
    tv.push_back(row(1, 0,0,0,  0,0,0,  1,  1,A1,0,1, 1, 0,1, 2'b00));
    tv.push_back(row(1, 0,0,0,  0,0,0,  0,  0,0,0,0, 0, 0,0, 2'b00));
    tv.push_back(rst_row());
    tv.push_back(row(1, 1,A0,0, 0,0,0,  0,  0,0,0,0, 0, 0,0, 2'b00));
    tv.push_back(row(1, 0,0,0,  1,A1,0, 0,  0,0,0,0, 0, 0,0, 2'b00));
    tv.push_back(row(1, 0,0,0,  1,A2,0, 0,  1,A0,0,0, 1, 0,0, 2'b00));
    tv.push_back(row(1, 0,0,0,  0,0,0,  0,  1,A0,0,0, 1, 0,0, 2'b10));
    tv.push_back(row(1, 0,0,0,  0,0,0,  1,  1,A0,0,0, 1, 1,0, 2'b10));
    tv.push_back(row(1, 0,0,0,  0,0,0,  0,  0,0,0,0, 0, 0,0, 2'b10));
    tv.push_back(row(1, 0,0,0,  0,0,0,  0,  1,A1,0,1, 1, 0,0, 2'b10));
    tv.push_back(row(1, 0,0,0,  0,0,0,  1,  1,A1,0,1, 1, 0,1, 2'b10));
    tv.push_back(row(1, 0,0,0,  0,0,0,  0,  0,0,0,0, 0, 0,0, 2'b10));

    foreach (tv[i]) begin
      if (tv[i].rs) begin
        reset_dut();
      end else begin
        for (int k = 0; k < tv[i].n; k++) begin
          step(tv[i].v0, tv[i].a0, tv[i].rw0, tv[i].v1, tv[i].a1, tv[i].rw1, tv[i].rdy);
          exp_out($sformatf("vec%0d.%0d", i, k), tv[i].ev, tv[i].ea, tv[i].erw, tv[i].eown,
                  tv[i].eb, tv[i].ec0, tv[i].ec1, tv[i].eovf, 1'b0);
        end
      end
    end

    // Test 3: write-back lock keeps port 1 ahead of a pending port 0.
    reset_dut();
    step(0,0,0, 1,A1,1, 0);  exp_out("wb.c0", 0,0,0,0, 0, 0,0, 2'b00, 0);
    step(1,A0,0, 0,0,0, 0);  exp_out("wb.c1", 0,0,0,0, 0, 0,0, 2'b00, 0);
    step(0,0,0, 0,0,0, 0);   exp_out("wb.c2", 1,A1,1,1, 1, 0,0, 2'b00, 0);
    step(0,0,0, 1,A2,0, 1);  exp_out("wb.c3", 1,A1,1,1, 1, 0,1, 2'b00, 0);
    step(0,0,0, 0,0,0, 0);   exp_out("wb.c4", 0,0,0,0, 0, 0,0, 2'b00, 0);
    step(0,0,0, 0,0,0, 0);   exp_out("wb.c5", 1,A2,0,1, 1, 0,0, 2'b00, 0);
    step(0,0,0, 0,0,0, 1);   exp_out("wb.c6", 1,A2,0,1, 1, 0,1, 2'b00, 0);
    step(0,0,0, 0,0,0, 0);   exp_out("wb.c7", 0,0,0,0, 0, 0,0, 2'b00, 0);
    step(0,0,0, 0,0,0, 0);   exp_out("wb.c8", 1,A0,0,0, 1, 0,0, 2'b00, 0);

    // Test 5: watchdog after TMO busy cycles; late ready still completes; ready while idle ignored.
    reset_dut();
    step(1,A0,0, 0,0,0, 0);  exp_out("to.pulse", 0,0,0,0, 0, 0,0, 2'b00, 0);
    idle_step();             exp_out("to.slot", 0,0,0,0, 0, 0,0, 2'b00, 0);
    for (int k = 0; k < TMO; k++) begin
      idle_step();           exp_out($sformatf("to.busy%0d", k), 1,A0,0,0, 1, 0,0, 2'b00, 0);
    end
    idle_step();             exp_out("to.set", 1,A0,0,0, 1, 0,0, 2'b00, 1);
    step(0,0,0, 0,0,0, 1);   exp_out("to.late", 1,A0,0,0, 1, 1,0, 2'b00, 1);
    step(0,0,0, 0,0,0, 1);   exp_out("to.idle_rdy", 0,0,0,0, 0, 0,0, 2'b00, 1);
    idle_step();             exp_out("to.after", 0,0,0,0, 0, 0,0, 2'b00, 1);

    // Test 6: asynchronous reset in the middle of a transaction.
    reset_dut();
    step(1,A0,0, 0,0,0, 0);
    step(0,0,0, 1,A1,0, 0);
    idle_step();             exp_out("ar.busy", 1,A0,0,0, 1, 0,0, 2'b00, 0);
    @(negedge clk);
    drive(0,0,0, 0,0,0, 1);
    #1 rst = 1'b1;
    #1;
    chk("ar.mem_req", 128'(mreq), 128'(0));
    chk("ar.owner", 128'(owner), 128'(0));
    exp_out("ar.async", 0,0,0,0, 0, 0,0, 2'b00, 0);
    #1 rst = 1'b0;
    mdata.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle_step();           exp_out($sformatf("ar.clean%0d", k), 0,0,0,0, 0, 0,0, 2'b00, 0);
    end
    step(0,0,0, 1,A2,0, 0);  exp_out("ar.pulse", 0,0,0,0, 0, 0,0, 2'b00, 0);
    idle_step();             exp_out("ar.slot", 0,0,0,0, 0, 0,0, 2'b00, 0);
    idle_step();             exp_out("ar.restart", 1,A2,0,1, 1, 0,0, 2'b00, 0);

    // Randomised traffic against the reference model.
    for (int blk = 0; blk < 4; blk++) begin
      reset_dut();
      model_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
        bit v0, v1, rw0, rw1, rdy;
        logic [31:0] a0, a1;
        v0 = ($urandom_range(0, 2) == 0); v1 = ($urandom_range(0, 2) == 0);
        rw0 = $urandom_range(0, 1) == 1;  rw1 = $urandom_range(0, 1) == 1;
        a0 = $urandom; a1 = $urandom;
        rdy = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
        step(v0, a0, rw0, v1, a1, rw1, rdy);
        chk("rnd.valid", 128'(mreq.valid), 128'(m_busy));
        chk("rnd.busy", 128'(busy), 128'(m_busy));
        if (m_busy) begin
          chk("rnd.addr", 128'(mreq.addr), 128'(m_cur.addr));
          chk("rnd.rw", 128'(mreq.rw), 128'(m_cur.rw));
          chk("rnd.data", mreq.data, m_cur.data);
          chk("rnd.owner", 128'(owner), 128'(m_own));
        end
        chk("rnd.c0_ready", 128'(c0_data.ready), 128'(rdy && m_busy && !m_own));
        chk("rnd.c1_ready", 128'(c1_data.ready), 128'(rdy && m_busy && m_own));
        chk("rnd.c0_data", c0_data.data, mdata.data);
        chk("rnd.c1_data", c1_data.data, mdata.data);
        chk("rnd.err_overflow", 128'(err_ovf), 128'(m_ovf));
        chk("rnd.err_timeout", 128'(err_to), 128'(m_to));
        model_edge(c0_req, c1_req, rdy);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
